// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS-subset main control FSM (IF/ID/EX/MEM/WB sequencing and datapath control decode)
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [4:0] ALUCtrl,
  output logic       Sign,
  output logic [2:0] State
);
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;
  logic [2:0] state, next_state;
  logic       r_type, r_alu, r_shift, r_jr, r_sign;
  logic       i_alu, i_sign, i_ext, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic [4:0] r_ctrl, i_ctrl;
  logic       pc_write, mem_read, mem_write, ir_write, reg_write;
  assign r_type = OpCode == 6'h00;
  assign r_jr   = r_type && Funct == 6'h08;
  assign r_sign = Funct inside {6'h20, 6'h22, 6'h2A};
  assign i_sign = OpCode inside {6'h08, 6'h0A};
  assign i_ext  = OpCode inside {6'h08, 6'h09, 6'h0A, 6'h0B};
  assign is_lui = OpCode == 6'h0F;
  assign is_lw  = OpCode == 6'h23;
  assign is_sw  = OpCode == 6'h2B;
  assign is_beq = OpCode == 6'h04;
  assign is_j   = OpCode == 6'h02;
  assign is_jal = OpCode == 6'h03;
  always_comb begin
    r_alu   = 1'b1;
    r_shift = 1'b0;
    r_ctrl  = 5'd0;
    case (Funct)
      6'h20, 6'h21: r_ctrl = 5'd0;
      6'h22, 6'h23: r_ctrl = 5'd1;
      6'h24:        r_ctrl = 5'd2;
      6'h25:        r_ctrl = 5'd3;
      6'h26:        r_ctrl = 5'd4;
      6'h27:        r_ctrl = 5'd5;
      6'h2A, 6'h2B: r_ctrl = 5'd9;
      6'h00:        begin r_alu = 1'b0; r_shift = 1'b1; r_ctrl = 5'd6; end
      6'h02:        begin r_alu = 1'b0; r_shift = 1'b1; r_ctrl = 5'd7; end
      6'h03:        begin r_alu = 1'b0; r_shift = 1'b1; r_ctrl = 5'd8; end
      default:      r_alu = 1'b0;
    endcase
  end
  always_comb begin
    i_alu  = 1'b1;
    i_ctrl = 5'd0;
    case (OpCode)
      6'h08, 6'h09: i_ctrl = 5'd0;
      6'h0A, 6'h0B: i_ctrl = 5'd9;
      6'h0C:        i_ctrl = 5'd2;
      6'h0D:        i_ctrl = 5'd3;
      default:      i_alu = 1'b0;
    endcase
  end
  always_comb begin
    next_state = S_IF;
    pc_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    IorD       = 1'b0;
    ExtOp      = 1'b0;
    RegDst     = 2'd0;
    MemtoReg   = 2'd0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    PCSource   = 2'd0;
    ALUCtrl    = 5'd0;
    Sign       = 1'b0;
    case (state)
      S_IF: begin
        mem_read   = 1'b1;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        ALUSrcB    = 2'd1;
        next_state = S_ID;
      end
      S_ID: begin
        ALUSrcB    = 2'd3;
        ExtOp      = 1'b1;
        next_state = S_EX;
      end
      S_EX: begin
        if (r_type && (r_alu || r_shift)) begin
          ALUCtrl    = r_ctrl;
          Sign       = r_sign;
          ALUSrcA    = r_shift ? 2'd2 : 2'd1;
          ALUSrcB    = r_shift ? 2'd2 : 2'd0;
          ExtOp      = r_shift;
          next_state = S_WB;
        end else if (r_jr) begin
          PCSource = 2'd3;
          pc_write = 1'b1;
        end else if (i_alu) begin
          ALUCtrl    = i_ctrl;
          Sign       = i_sign;
          ExtOp      = i_ext;
          ALUSrcA    = 2'd1;
          ALUSrcB    = 2'd2;
          next_state = S_WB;
        end else if (is_lui) begin
          ALUSrcA    = 2'd3;
          ALUCtrl    = 5'd10;
          next_state = S_WB;
        end else if (is_lw || is_sw) begin
          ALUSrcA    = 2'd1;
          ALUSrcB    = 2'd2;
          ExtOp      = 1'b1;
          next_state = S_MEM;
        end else if (is_beq) begin
          ALUCtrl  = 5'd1;
          Sign     = 1'b1;
          ALUSrcA  = 2'd1;
          PCSource = 2'd1;
          pc_write = Zero;
        end else if (is_j || is_jal) begin
          PCSource  = 2'd2;
          pc_write  = 1'b1;
          reg_write = is_jal;
          RegDst    = is_jal ? 2'd2 : 2'd0;
          MemtoReg  = is_jal ? 2'd2 : 2'd0;
        end
      end
      S_MEM: begin
        IorD       = 1'b1;
        mem_read   = is_lw;
        mem_write  = is_sw;
        next_state = is_lw ? S_WB : S_IF;
      end
      S_WB: begin
        reg_write = 1'b1;
        RegDst    = r_type ? 2'd1 : 2'd0;
        MemtoReg  = is_lw ? 2'd1 : 2'd0;
      end
      default: next_state = S_IF;
    endcase
  end
  // reset must suppress every side effect in the cycle it is asserted
  assign PCWrite  = pc_write & ~reset;
  assign MemRead  = mem_read & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign IRWrite  = ir_write & ~reset;
  assign RegWrite = reg_write & ~reset;
  assign State    = state;
  always_ff @(posedge clk)
    if (reset) state <= S_IF;
    else       state <= next_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction streams checked against an instruction-class reference model
module tb_multicycle_ctrl;
  typedef struct packed {
    logic       pcw, iord, mr, mw, irw, rw, ext;
    logic [1:0] rd, m2r, sa, sb, pcs;
    logic [4:0] alu;
    logic       sgn;
  } ctl_t;
  localparam int C_RALU = 0, C_RSH = 1, C_JR = 2, C_IALU = 3, C_LUI = 4, C_LW = 5,
                 C_SW = 6, C_BEQ = 7, C_J = 8, C_JAL = 9, C_NOP = 10;
  logic       clk = 1'b0, reset, Zero;
  logic [5:0] OpCode, Funct;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, Sign;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [4:0] ALUCtrl;
  logic [2:0] State;
  ctl_t       ctl_bus;
  int         n_tests = 0, n_fail = 0;
  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ExtOp(ExtOp), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUCtrl(ALUCtrl), .Sign(Sign), .State(State)
  );
  assign ctl_bus = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp,
                    RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUCtrl, Sign};
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn inside {[6'h20:6'h27], 6'h2A, 6'h2B}) return C_RALU;
      if (fn inside {6'h00, 6'h02, 6'h03}) return C_RSH;
      return fn == 6'h08 ? C_JR : C_NOP;
    end
    if (op inside {[6'h08:6'h0D]}) return C_IALU;
    case (op)
      6'h0F:   return C_LUI;
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h02:   return C_J;
      6'h03:   return C_JAL;
      default: return C_NOP;
    endcase
  endfunction
  function automatic ctl_t exp_ctl(input int st, input int cls, input logic [5:0] op,
                                   input logic [5:0] fn, input logic z, input logic rst);
    ctl_t c = '0;
    int   f = int'(fn), o = int'(op);
    if (st == 0) begin c.pcw = 1; c.mr = 1; c.irw = 1; c.sb = 1; end
    if (st == 1) begin c.sb = 3; c.ext = 1; end
    if (st == 2) begin
      if (cls == C_RALU) begin
        c.alu = 5'(f <= 'h23 ? (f - 'h20) / 2 : f <= 'h27 ? f - 'h22 : 9);
        c.sgn = fn inside {6'h20, 6'h22, 6'h2A}; c.sa = 1;
      end
      if (cls == C_RSH) begin c.alu = 5'(f == 0 ? 6 : f + 5); c.sa = 2; c.sb = 2; c.ext = 1; end
      if (cls == C_JR) begin c.pcs = 3; c.pcw = 1; end
      if (cls == C_IALU) begin
        c.alu = 5'(o < 'h0A ? 0 : o < 'h0C ? 9 : o - 'h0A);
        c.sgn = op inside {6'h08, 6'h0A}; c.ext = o < 'h0C; c.sa = 1; c.sb = 2;
      end
      if (cls == C_LUI) begin c.sa = 3; c.alu = 10; end
      if (cls == C_LW || cls == C_SW) begin c.sa = 1; c.sb = 2; c.ext = 1; end
      if (cls == C_BEQ) begin c.alu = 1; c.sgn = 1; c.sa = 1; c.pcs = 1; c.pcw = z; end
      if (cls == C_J || cls == C_JAL) begin c.pcs = 2; c.pcw = 1; end
      if (cls == C_JAL) begin c.rw = 1; c.rd = 2; c.m2r = 2; end
    end
    if (st == 3) begin c.iord = 1; c.mr = cls == C_LW; c.mw = cls == C_SW; end
    if (st == 4) begin c.rw = 1; c.rd = 2'(cls == C_RALU || cls == C_RSH); c.m2r = 2'(cls == C_LW); end
    if (rst) begin c.pcw = 0; c.mr = 0; c.mw = 0; c.irw = 0; c.rw = 0; end
    return c;
  endfunction
  // zmode: 0/1 force Zero, 2 randomizes it; abort_at names the cycle index that gets reset
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode, input int abort_at);
    int cls = classify(op, fn);
    int path[$];
    path = '{0, 1, 2};
    if (cls == C_LW) path = '{0, 1, 2, 3, 4};
    else if (cls == C_SW) path = '{0, 1, 2, 3};
    else if (cls inside {C_RALU, C_RSH, C_IALU, C_LUI}) path = '{0, 1, 2, 4};
    for (int i = 0; i < path.size(); i++) begin
      @(negedge clk);
      OpCode = op;
      Funct  = fn;
      Zero   = zmode == 2 ? 1'($urandom) : 1'(zmode);
      reset  = i == abort_at;
      #1;
      check($sformatf("state op=%h fn=%h cyc%0d", op, fn, i), 32'(State), 32'(path[i]));
      check($sformatf("ctl op=%h fn=%h st%0d z%0d r%0d", op, fn, path[i], Zero, reset),
            32'(ctl_bus), 32'(exp_ctl(path[i], cls, op, fn, Zero, reset)));
      if (reset) break;
    end
  endtask
  function automatic logic [5:0] pick_op();
    logic [5:0] ops [15] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                             6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
    return $urandom_range(7) == 0 ? 6'($urandom) : ops[$urandom_range(14)];
  endfunction
  function automatic logic [5:0] pick_fn();
    logic [5:0] fns [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h08};
    return $urandom_range(7) == 0 ? 6'($urandom) : fns[$urandom_range(14)];
  endfunction
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1; Zero = 1'b0; OpCode = 6'h00; Funct = 6'h20;
    repeat (2) begin
      @(negedge clk); #1;
      check("reset state", 32'(State), 32'd0);
      check("reset ctl", 32'(ctl_bus), 32'(exp_ctl(0, C_RALU, 6'h00, 6'h20, 1'b0, 1'b1)));
    end
    run_instr(6'h00, 6'h2B, 2, -1);
    run_instr(6'h00, 6'h03, 2, -1);
    run_instr(6'h00, 6'h27, 2, -1);
    run_instr(6'h23, 6'h11, 2, -1);
    run_instr(6'h2B, 6'h05, 2, -1);
    run_instr(6'h04, 6'h00, 1, -1);
    run_instr(6'h04, 6'h00, 0, -1);
    run_instr(6'h03, 6'h00, 2, -1);
    run_instr(6'h3F, 6'h00, 2, -1);
    run_instr(6'h00, 6'h08, 2, -1);
    run_instr(6'h2B, 6'h00, 2, 3);
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op = pick_op();
      logic [5:0] fn = op == 6'h00 ? pick_fn() : 6'($urandom);
      run_instr(op, fn, 2, $urandom_range(15) == 0 ? int'($urandom_range(4)) : -1);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("final state", 32'(State), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
